// File: rtl/commit_stage_pkg.sv
// Shared ROB-side definitions and the commit-stage state encoding.
// Imported by the commit-stage interface and the commit stage itself.
package commit_stage_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 4;
    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic            valid;
        logic            wr_mem;
        logic [4:0]      dest_reg;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] dest_addr;
        logic            value_ready;
        logic            address_ready;
    } ROB_ENTRY;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        STORE_REQ = 1'b1
    } COMMIT_STATE;

    function automatic logic is_committable(input ROB_ENTRY entry, input logic ready);
        return entry.valid && ready;
    endfunction

endpackage

// File: rtl/commit_stage_if.sv
// Bundle of ROB-head, register-file, map-table and store-port signals around the commit stage.
// The commit stage connects through the master modport; its environment uses slave.
interface commit_stage_if #(
    parameter int CNT_W = 32
);
    import commit_stage_pkg::*;

    ROB_ENTRY                 head_entry;
    logic                     head_ready;
    logic [ROB_TAG_LEN-1:0]   head_tag;
    logic                     commit_pop;
    logic                     rf_wr_en;
    logic [4:0]               rf_wr_idx;
    logic [XLEN-1:0]          rf_wr_data;
    logic                     mt_clear_en;
    logic [4:0]               mt_clear_reg;
    logic [ROB_TAG_LEN-1:0]   mt_clear_tag;
    logic                     mem_req;
    logic [XLEN-1:0]          mem_addr;
    logic [XLEN-1:0]          mem_data;
    logic                     mem_ack;
    logic                     store_busy;
    logic [CNT_W-1:0]         retired_count;

    modport master (
        input  head_entry, head_ready, head_tag, mem_ack,
        output commit_pop, rf_wr_en, rf_wr_idx, rf_wr_data,
               mt_clear_en, mt_clear_reg, mt_clear_tag,
               mem_req, mem_addr, mem_data, store_busy, retired_count
    );

    modport slave (
        output head_entry, head_ready, head_tag, mem_ack,
        input  commit_pop, rf_wr_en, rf_wr_idx, rf_wr_data,
               mt_clear_en, mt_clear_reg, mt_clear_tag,
               mem_req, mem_addr, mem_data, store_busy, retired_count
    );

endinterface

// File: rtl/commit_stage.sv
// In-order retirement stage: writes register results back, handshakes stores to memory,
// and pops the ROB head only once the instruction has fully retired.
module commit_stage
    import commit_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic clock,
    input  logic reset,
    commit_stage_if.master bus
);

    COMMIT_STATE          state_q, state_d;
    logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]      mem_data_q, mem_data_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                   pop_s;
    logic                   rf_wr_en_s;
    logic [4:0]             rf_wr_idx_s;
    logic [XLEN-1:0]        rf_wr_data_s;
    logic                   mt_clear_en_s;
    logic [4:0]             mt_clear_reg_s;
    logic [ROB_TAG_LEN-1:0] mt_clear_tag_s;
    logic                   head_ok_s;
    logic                   head_unused_s;

    assign head_ok_s = is_committable(bus.head_entry, bus.head_ready);
    // Per-field readiness is already folded into head_ready by the ROB.
    assign head_unused_s = bus.head_entry.value_ready & bus.head_entry.address_ready;

    // Next-state and same-cycle commit strobes; strobes held low while reset is asserted.
    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        pop_s          = 1'b0;
        rf_wr_en_s     = 1'b0;
        rf_wr_idx_s    = 5'd0;
        rf_wr_data_s   = {XLEN{1'b0}};
        mt_clear_en_s  = 1'b0;
        mt_clear_reg_s = 5'd0;
        mt_clear_tag_s = {ROB_TAG_LEN{1'b0}};
        if (reset) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (head_ok_s && bus.head_entry.wr_mem) begin
                        state_d    = STORE_REQ;
                        mem_addr_d = bus.head_entry.dest_addr;
                        mem_data_d = bus.head_entry.value;
                    end else if (head_ok_s) begin
                        pop_s = 1'b1;
                        if (bus.head_entry.dest_reg != ZERO_REG) begin
                            rf_wr_en_s     = 1'b1;
                            rf_wr_idx_s    = bus.head_entry.dest_reg;
                            rf_wr_data_s   = bus.head_entry.value;
                            mt_clear_en_s  = 1'b1;
                            mt_clear_reg_s = bus.head_entry.dest_reg;
                            mt_clear_tag_s = bus.head_tag;
                        end else begin
                            rf_wr_en_s = 1'b0;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                STORE_REQ: begin
                    // Head is frozen here because nothing pops until the ack arrives.
                    if (bus.mem_ack) begin
                        pop_s   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = STORE_REQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Retired-instruction counter wraps naturally at 2^CNT_W.
    always_comb begin
        count_d = count_q;
        if (pop_s) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State, store latch and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_addr_q <= {XLEN{1'b0}};
            mem_data_q <= {XLEN{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            count_q    <= count_d;
        end
    end

    assign bus.commit_pop    = pop_s;
    assign bus.rf_wr_en      = rf_wr_en_s;
    assign bus.rf_wr_idx     = rf_wr_idx_s;
    assign bus.rf_wr_data    = rf_wr_data_s;
    assign bus.mt_clear_en   = mt_clear_en_s;
    assign bus.mt_clear_reg  = mt_clear_reg_s;
    assign bus.mt_clear_tag  = mt_clear_tag_s;
    assign bus.mem_req       = (state_q == STORE_REQ);
    assign bus.store_busy    = (state_q == STORE_REQ);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_data      = mem_data_q;
    assign bus.retired_count = count_q;

endmodule

// File: tb/tb_commit_stage.sv
// Directed testbench for commit_stage: register commits, stores, stray acks,
// reset during a store and back-to-back retirement.
module tb_commit_stage;
    import commit_stage_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    commit_stage_if #(.CNT_W(32)) bus();

    commit_stage #(.CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_head(input logic v, input logic st, input logic [4:0] rd,
                            input logic [31:0] val, input logic [31:0] addr);
        bus.head_entry.valid         = v;
        bus.head_entry.wr_mem        = st;
        bus.head_entry.dest_reg      = rd;
        bus.head_entry.value         = val;
        bus.head_entry.dest_addr     = addr;
        bus.head_entry.value_ready   = 1'b1;
        bus.head_entry.address_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ack = 1'b0;
        bus.head_ready = 1'b1;
        bus.head_tag = 4'd1;
        set_head(1'b1, 1'b0, 5'd9, 32'h55, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clock);
        n_checks++; if (bus.commit_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %0b expected 0", bus.commit_pop); end
        n_checks++; if (bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_rf_en: got %0b expected 0", bus.rf_wr_en); end
        n_checks++; if (bus.mt_clear_en !== 1'b0) begin n_fail++; $display("FAIL reset_mt_en: got %0b expected 0", bus.mt_clear_en); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b expected 0", bus.mem_req); end
        n_checks++; if (bus.store_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.store_busy); end
        n_checks++; if (bus.retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.retired_count); end
        n_checks++; if (bus.mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        next_cycle();
        reset = 1'b0;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reg_commit();
        set_head(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
        bus.head_ready = 1'b1;
        bus.head_tag = 4'd2;
        @(negedge clock);
        n_checks++; if (bus.commit_pop !== 1'b1) begin n_fail++; $display("FAIL reg_pop: got %0b expected 1", bus.commit_pop); end
        n_checks++; if (bus.rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL reg_rf_en: got %0b expected 1", bus.rf_wr_en); end
        n_checks++; if (bus.rf_wr_idx !== 5'd5) begin n_fail++; $display("FAIL reg_rf_idx: got %0d expected 5", bus.rf_wr_idx); end
        n_checks++; if (bus.rf_wr_data !== 32'h1234) begin n_fail++; $display("FAIL reg_rf_data: got %h expected 1234", bus.rf_wr_data); end
        n_checks++; if (bus.mt_clear_en !== 1'b1) begin n_fail++; $display("FAIL reg_mt_en: got %0b expected 1", bus.mt_clear_en); end
        n_checks++; if (bus.mt_clear_reg !== 5'd5) begin n_fail++; $display("FAIL reg_mt_reg: got %0d expected 5", bus.mt_clear_reg); end
        n_checks++; if (bus.mt_clear_tag !== 4'd2) begin n_fail++; $display("FAIL reg_mt_tag: got %0d expected 2", bus.mt_clear_tag); end
        n_checks++; if (bus.retired_count !== 32'd0) begin n_fail++; $display("FAIL reg_count_before: got %0d expected 0", bus.retired_count); end
        next_cycle();
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        n_checks++; if (bus.retired_count !== 32'd1) begin n_fail++; $display("FAIL reg_count_after: got %0d expected 1", bus.retired_count); end
        n_checks++; if (bus.commit_pop !== 1'b0) begin n_fail++; $display("FAIL reg_invalid_pop: got %0b expected 0", bus.commit_pop); end
        next_cycle();
    endtask

    task automatic test_zero_reg();
        set_head(1'b1, 1'b0, 5'd0, 32'hFFFF, 32'h0);
        bus.head_ready = 1'b1;
        bus.head_tag = 4'd3;
        @(negedge clock);
        n_checks++; if (bus.commit_pop !== 1'b1) begin n_fail++; $display("FAIL zero_pop: got %0b expected 1", bus.commit_pop); end
        n_checks++; if (bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL zero_rf_en: got %0b expected 0", bus.rf_wr_en); end
        n_checks++; if (bus.mt_clear_en !== 1'b0) begin n_fail++; $display("FAIL zero_mt_en: got %0b expected 0", bus.mt_clear_en); end
        next_cycle();
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        n_checks++; if (bus.retired_count !== 32'd2) begin n_fail++; $display("FAIL zero_count: got %0d expected 2", bus.retired_count); end
        next_cycle();
    endtask

    task automatic test_store();
        int pops;
        pops = 0;
        set_head(1'b1, 1'b1, 5'd0, 32'hAB, 32'h100);
        bus.head_ready = 1'b1;
        bus.mem_ack = 1'b0;
        @(negedge clock);
        if (bus.commit_pop === 1'b1) pops++;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL store_launch_req: got %0b expected 0", bus.mem_req); end
        n_checks++; if (bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL store_launch_rf: got %0b expected 0", bus.rf_wr_en); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 2) set_head(1'b1, 1'b0, 5'd7, 32'hDEAD, 32'h0);
            bus.mem_ack = (c == 3) ? 1'b1 : 1'b0;
            @(negedge clock);
            if (bus.commit_pop === 1'b1) pops++;
            n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL store_req_c%0d: got %0b expected 1", c, bus.mem_req); end
            n_checks++; if (bus.store_busy !== 1'b1) begin n_fail++; $display("FAIL store_busy_c%0d: got %0b expected 1", c, bus.store_busy); end
            n_checks++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL store_addr_c%0d: got %h expected 100", c, bus.mem_addr); end
            n_checks++; if (bus.mem_data !== 32'hAB) begin n_fail++; $display("FAIL store_data_c%0d: got %h expected ab", c, bus.mem_data); end
            n_checks++; if (bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL store_rf_c%0d: got %0b expected 0", c, bus.rf_wr_en); end
            n_checks++; if (bus.commit_pop !== (c == 3)) begin n_fail++; $display("FAIL store_pop_c%0d: got %0b expected %0b", c, bus.commit_pop, (c == 3)); end
        end
        n_checks++; if (pops != 1) begin n_fail++; $display("FAIL store_pop_count: got %0d expected 1", pops); end
        next_cycle();
        bus.mem_ack = 1'b0;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL store_req_drop: got %0b expected 0", bus.mem_req); end
        n_checks++; if (bus.store_busy !== 1'b0) begin n_fail++; $display("FAIL store_busy_drop: got %0b expected 0", bus.store_busy); end
        n_checks++; if (bus.retired_count !== 32'd3) begin n_fail++; $display("FAIL store_count: got %0d expected 3", bus.retired_count); end
        next_cycle();
    endtask

    task automatic test_stray_ack();
        set_head(1'b1, 1'b0, 5'd7, 32'h77, 32'h0);
        bus.head_ready = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clock);
        n_checks++; if (bus.commit_pop !== 1'b0) begin n_fail++; $display("FAIL stray_pop: got %0b expected 0", bus.commit_pop); end
        n_checks++; if (bus.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL stray_rf: got %0b expected 0", bus.rf_wr_en); end
        next_cycle();
        set_head(1'b0, 1'b1, 5'd7, 32'h77, 32'h40);
        bus.head_ready = 1'b1;
        @(negedge clock);
        n_checks++; if (bus.store_busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy: got %0b expected 0", bus.store_busy); end
        n_checks++; if (bus.commit_pop !== 1'b0) begin n_fail++; $display("FAIL stray_invalid_pop: got %0b expected 0", bus.commit_pop); end
        next_cycle();
        bus.mem_ack = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL stray_req: got %0b expected 0", bus.mem_req); end
        n_checks++; if (bus.retired_count !== 32'd3) begin n_fail++; $display("FAIL stray_count: got %0d expected 3", bus.retired_count); end
        next_cycle();
    endtask

    task automatic test_reset_mid_store();
        set_head(1'b1, 1'b1, 5'd0, 32'hCD, 32'h200);
        bus.head_ready = 1'b1;
        bus.mem_ack = 1'b0;
        next_cycle();
        @(negedge clock);
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_store_req_up: got %0b expected 1", bus.mem_req); end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        set_head(1'b1, 1'b1, 5'd0, 32'hEF, 32'h300);
        @(negedge clock);
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_store_req: got %0b expected 0", bus.mem_req); end
        n_checks++; if (bus.store_busy !== 1'b0) begin n_fail++; $display("FAIL rst_store_busy: got %0b expected 0", bus.store_busy); end
        n_checks++; if (bus.retired_count !== 32'd0) begin n_fail++; $display("FAIL rst_store_count: got %0d expected 0", bus.retired_count); end
        next_cycle();
        bus.mem_ack = 1'b1;
        @(negedge clock);
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL relaunch_req: got %0b expected 1", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 32'h300) begin n_fail++; $display("FAIL relaunch_addr: got %h expected 300", bus.mem_addr); end
        n_checks++; if (bus.mem_data !== 32'hEF) begin n_fail++; $display("FAIL relaunch_data: got %h expected ef", bus.mem_data); end
        n_checks++; if (bus.commit_pop !== 1'b1) begin n_fail++; $display("FAIL relaunch_pop: got %0b expected 1", bus.commit_pop); end
        next_cycle();
        bus.mem_ack = 1'b0;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL relaunch_req_drop: got %0b expected 0", bus.mem_req); end
        n_checks++; if (bus.retired_count !== 32'd1) begin n_fail++; $display("FAIL relaunch_count: got %0d expected 1", bus.retired_count); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [5:0] pop_hist;
        logic [5:0] pop_exp;
        pop_hist = 6'd0;
        pop_exp  = 6'b101111;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        bus.head_ready = 1'b1;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_head(1'b1, 1'b0, 5'(i + 1), 32'h10 + 32'(i), 32'h0);
            bus.head_tag = 4'(i + 4);
            @(negedge clock);
            pop_hist[i] = bus.commit_pop;
            n_checks++; if (bus.rf_wr_idx !== 5'(i + 1)) begin n_fail++; $display("FAIL b2b_idx_%0d: got %0d expected %0d", i, bus.rf_wr_idx, i + 1); end
            n_checks++; if (bus.mt_clear_tag !== 4'(i + 4)) begin n_fail++; $display("FAIL b2b_tag_%0d: got %0d expected %0d", i, bus.mt_clear_tag, i + 4); end
            next_cycle();
        end
        set_head(1'b1, 1'b1, 5'd0, 32'h55, 32'h40);
        @(negedge clock);
        pop_hist[4] = bus.commit_pop;
        next_cycle();
        bus.mem_ack = 1'b1;
        @(negedge clock);
        pop_hist[5] = bus.commit_pop;
        n_checks++; if (bus.mem_addr !== 32'h40) begin n_fail++; $display("FAIL b2b_store_addr: got %h expected 40", bus.mem_addr); end
        next_cycle();
        bus.mem_ack = 1'b0;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clock);
        n_checks++; if (pop_hist !== pop_exp) begin n_fail++; $display("FAIL b2b_pop_pattern: got %b expected %b", pop_hist, pop_exp); end
        n_checks++; if (bus.retired_count !== 32'd5) begin n_fail++; $display("FAIL b2b_count: got %0d expected 5", bus.retired_count); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req_drop: got %0b expected 0", bus.mem_req); end
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.head_ready = 1'b0;
        bus.head_tag   = 4'd0;
        bus.mem_ack    = 1'b0;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        test_reset();
        test_reg_commit();
        test_zero_reg();
        test_store();
        test_stray_ack();
        test_reset_mid_store();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
